// File: rtl/sync_fifo_pkg.sv
// Shared sizing helpers and types for the parametrised synchronous FIFO.
// Imported by sync_fifo_p and fifo_mem.
package sync_fifo_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;

  typedef enum logic [1:0] {
    FILL_EMPTY,
    FILL_PARTIAL,
    FILL_FULL
  } fill_e;

  function automatic int ptr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return ptr_w(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

  function automatic bit levels_ok(
    input int ae,
    input int af,
    input int depth
  );
    return (ae < af) && (af <= depth);
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port and one
// registered read port whose output holds between reads.
module fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] rdata_d;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[raddr];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo_p.sv
// Parametrised single-clock FIFO with occupancy count, programmable
// almost flags and one-cycle overflow/underflow pulses.
module sync_fifo_p
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  localparam int PTR_W   = ptr_w(DEPTH),
  localparam int CNT_W   = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_i,
  input  logic             write_enable,
  input  logic             read_enable,
  output logic [WIDTH-1:0] data_o,
  output logic             read_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic             underflow
);

  if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
    $error("sync_fifo_p: DEPTH must be a power of two >= 2");
  end

  if (!levels_ok(AE_LEVEL, AF_LEVEL, DEPTH)) begin : g_bad_levels
    $error("sync_fifo_p: need AE_LEVEL < AF_LEVEL <= DEPTH");
  end

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LEVEL);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             read_valid_q, read_valid_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             wr_ok;
  logic             rd_ok;
  fill_e            fill;

  always_comb begin
    fill = FILL_PARTIAL;
    unique case (1'b1)
      (count_q == '0):     fill = FILL_EMPTY;
      (count_q == DEPTH_C): fill = FILL_FULL;
      default: ;
    endcase
  end

  assign full         = (fill == FILL_FULL);
  assign empty        = (fill == FILL_EMPTY);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);

  // A read frees a slot, so a write into a full FIFO still lands.
  // No fall-through: an empty FIFO never serves a same-cycle write.
  always_comb begin
    rd_ok = read_enable && !empty;
    wr_ok = write_enable && (!full || rd_ok);

    wr_ptr_d = wr_ptr_q + PTR_W'(wr_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(rd_ok);

    count_d = count_q;
    unique case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    read_valid_d = rd_ok;
    overflow_d   = write_enable && !wr_ok;
    underflow_d  = read_enable && !rd_ok;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      read_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      read_valid_q <= read_valid_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PTR_W)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_ok),
    .waddr (wr_ptr_q),
    .wdata (data_i),
    .re    (rd_ok),
    .raddr (rd_ptr_q),
    .rdata (data_o)
  );

  assign count      = count_q;
  assign read_valid = read_valid_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

endmodule

// File: tb/tb_sync_fifo_p.sv
// Scoreboard bench for sync_fifo_p: stimulus queues expected read data,
// a monitor pops and compares whenever read_valid is seen.
module tb_sync_fifo_p;

  localparam int W = 8;
  localparam int D = 16;

  logic         clk;
  logic         rst;
  logic [W-1:0] data_i;
  logic         write_enable;
  logic         read_enable;
  logic [W-1:0] data_o;
  logic         read_valid;
  logic         full;
  logic         empty;
  logic         almost_full;
  logic         almost_empty;
  logic [4:0]   count;
  logic         overflow;
  logic         underflow;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] mdl_q[$];
  logic [W-1:0] exp_q[$];
  int           m_cnt;

  sync_fifo_p #(
    .WIDTH    (W),
    .DEPTH    (D),
    .AF_LEVEL (D - 2),
    .AE_LEVEL (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .data_i       (data_i),
    .write_enable (write_enable),
    .read_enable  (read_enable),
    .data_o       (data_o),
    .read_valid   (read_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Monitor: every presented read is matched against the scoreboard.
  always @(posedge clk) begin
    #1;
    if (read_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_read_valid", 1, 0);
      end else begin
        check("rd_data", int'(data_o), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic step(input logic we, input logic re, input logic [W-1:0] d);
    bit m_rd;
    bit m_wr;
    @(negedge clk);
    write_enable = we;
    read_enable  = re;
    data_i       = d;
    m_rd = re && (m_cnt != 0);
    m_wr = we && ((m_cnt != D) || m_rd);
    if (m_rd) exp_q.push_back(mdl_q.pop_front());
    if (m_wr) mdl_q.push_back(d);
    m_cnt = mdl_q.size();
    @(posedge clk);
    #1;
    check("count", int'(count), m_cnt);
    check("full", int'(full), int'(m_cnt == D));
    check("empty", int'(empty), int'(m_cnt == 0));
    check("almost_full", int'(almost_full), int'(m_cnt >= D - 2));
    check("almost_empty", int'(almost_empty), int'(m_cnt <= 2));
    check("overflow", int'(overflow), int'(we && !m_wr));
    check("underflow", int'(underflow), int'(re && !m_rd));
    check("read_valid", int'(read_valid), int'(m_rd));
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_count"}, int'(count), 0);
    check({tag, "_empty"}, int'(empty), 1);
    check({tag, "_full"}, int'(full), 0);
    check({tag, "_ae"}, int'(almost_empty), 1);
    check({tag, "_af"}, int'(almost_full), 0);
    check({tag, "_rvalid"}, int'(read_valid), 0);
    check({tag, "_data_o"}, int'(data_o), 0);
    check({tag, "_ovf"}, int'(overflow), 0);
    check({tag, "_udf"}, int'(underflow), 0);
  endtask

  initial begin
    rst          = 1'b0;
    data_i       = '0;
    write_enable = 1'b0;
    read_enable  = 1'b0;
    m_cnt        = 0;
    #1;
    reset_checks("rst0");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Fill with 0x01..0x10, then one rejected write.
    for (int i = 1; i <= D; i++) step(1'b1, 1'b0, W'(i));
    check("filled_full", int'(full), 1);
    check("filled_count", int'(count), 16);
    step(1'b1, 1'b0, 8'hEE);
    check("ovf_pulse", int'(overflow), 1);
    check("ovf_count", int'(count), 16);
    step(1'b0, 1'b0, 8'h00);
    check("ovf_one_cycle", int'(overflow), 0);

    // Drain back to back, then one rejected read.
    for (int i = 1; i <= D; i++) step(1'b0, 1'b1, 8'h00);
    check("drain_last", int'(data_o), 8'h10);
    check("drain_empty", int'(empty), 1);
    step(1'b0, 1'b1, 8'h00);
    check("udf_pulse", int'(underflow), 1);
    check("udf_rvalid", int'(read_valid), 0);
    check("udf_data_hold", int'(data_o), 8'h10);

    // Full with simultaneous write and read.
    for (int i = 1; i <= D; i++) step(1'b1, 1'b0, W'(i));
    step(1'b1, 1'b1, 8'hAA);
    check("fullrw_data", int'(data_o), 8'h01);
    check("fullrw_count", int'(count), 16);
    check("fullrw_ovf", int'(overflow), 0);
    for (int i = 1; i <= D; i++) step(1'b0, 1'b1, 8'h00);
    check("fullrw_aa_last", int'(data_o), 8'hAA);
    step(1'b0, 1'b0, 8'h00);

    // Empty with simultaneous write and read: no fall-through.
    step(1'b1, 1'b1, 8'h55);
    check("emptyrw_udf", int'(underflow), 1);
    check("emptyrw_count", int'(count), 1);
    step(1'b0, 1'b1, 8'h00);
    check("emptyrw_data", int'(data_o), 8'h55);

    // Random interleaving across several pointer wraps.
    for (int i = 0; i < 3 * D; i++) begin
      step(1'($urandom_range(0, 99) < 60),
           1'($urandom_range(0, 99) < 50),
           W'($urandom));
    end
    while (m_cnt != 0) step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 8'h00);

    // Asynchronous reset mid-operation with five entries held.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, W'(8'h30 + i));
    step(1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b0, 8'h35);
    check("pre_rst_count", int'(count), 5);
    @(negedge clk);
    write_enable = 1'b0;
    read_enable  = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    reset_checks("midrst");
    mdl_q.delete();
    m_cnt = 0;
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 1'b0, 8'h77);
    step(1'b0, 1'b1, 8'h00);
    check("post_rst_data", int'(data_o), 8'h77);
    step(1'b0, 1'b0, 8'h00);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
